// File: rtl/bmain_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bmain_pkg
// Brief    : Shared types and constants for bmain masters, slaves and arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bmain_pkg;

    localparam int BMAIN_BEATS = 4;
    localparam int BMAIN_AW    = 26;
    localparam int BMAIN_DW    = 32;

    localparam logic BMAIN_CMD_READ  = 1'b0;
    localparam logic BMAIN_CMD_FETCH = 1'b1;

    typedef logic [1:0] bmain_state_t;

    localparam bmain_state_t c_ST_IDLE = 2'd0;
    localparam bmain_state_t c_ST_CMD  = 2'd1;
    localparam bmain_state_t c_ST_RESP = 2'd2;

    // Width of a beat counter that wraps once per burst.
    function automatic int bmain_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmain_beat_check.sv
`default_nettype none
// ============================================================================
// Module   : bmain_beat_check
// Brief    : Read-burst length checker; pulses o_proto_err after a bad beat.
// Revision : 1.0 - initial release
// ============================================================================
module bmain_beat_check
    import bmain_pkg::*;
#(
    parameter int BEATS = BMAIN_BEATS
) (
    input  logic clk_core,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_beat,
    input  logic i_last,
    output logic o_proto_err
);

    localparam int              c_CW       = bmain_cnt_w(BEATS);
    localparam logic [c_CW-1:0] c_LAST_CNT = c_CW'(BEATS - 1);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    logic [c_CW-1:0] r_count;
    logic            r_proto_err;
    logic            w_at_end;
    logic            w_violation;

    assign w_at_end    = (r_count == c_LAST_CNT);
    // A last beat must land on the final slot, and the final slot must be last.
    assign w_violation = i_beat & (i_last ? ~w_at_end : w_at_end);

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_violation;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_beat) begin
                r_count <= r_count + c_ONE;
            end
        end
    end

    assign o_proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: rtl/bmain_arb.sv
`default_nettype none
// ============================================================================
// Module   : bmain_arb
// Brief    : Round-robin two-master arbiter onto one bmain slave port.
// Revision : 1.0 - initial release
// ============================================================================
module bmain_arb
    import bmain_pkg::*;
#(
    parameter int BEATS = BMAIN_BEATS
) (
    input  logic                clk_core,
    input  logic                reset_n,
    // master 0 (instruction fetch)
    input  logic                m0_cvalid,
    output logic                arb_cready_m0,
    input  logic                m0_cmd,
    input  logic [BMAIN_AW-1:0] m0_addr,
    output logic                arb_rvalid_m0,
    input  logic                m0_rready,
    output logic                arb_error_m0,
    input  logic                m0_eack,
    // master 1 (data)
    input  logic                m1_cvalid,
    output logic                arb_cready_m1,
    input  logic                m1_cmd,
    input  logic [BMAIN_AW-1:0] m1_addr,
    output logic                arb_rvalid_m1,
    input  logic                m1_rready,
    output logic                arb_error_m1,
    input  logic                m1_eack,
    // broadcast read data
    output logic                arb_rlast,
    output logic [BMAIN_DW-1:0] arb_rdata,
    // slave port
    output logic                arb_cvalid,
    input  logic                s_cready,
    output logic                arb_cmd,
    output logic [BMAIN_AW-1:0] arb_addr,
    input  logic                s_rvalid,
    input  logic                s_rlast,
    input  logic [BMAIN_DW-1:0] s_rdata,
    output logic                arb_rready,
    input  logic                s_error,
    output logic                arb_eack,
    output logic                arb_proto_err
);

    bmain_state_t r_state;
    bmain_state_t w_state_nxt;
    logic         r_grant;
    logic         w_grant_nxt;
    logic         r_last_grant;
    logic         w_last_grant_nxt;

    logic w_in_cmd;
    logic w_in_resp;
    logic w_sel_rready;
    logic w_sel_eack;
    logic w_cmd_hs;
    logic w_beat;
    logic w_end_read;
    logic w_end_err;

    assign w_in_cmd     = (r_state == c_ST_CMD);
    assign w_in_resp    = (r_state == c_ST_RESP);
    assign w_sel_rready = r_grant ? m1_rready : m0_rready;
    assign w_sel_eack   = r_grant ? m1_eack   : m0_eack;

    assign w_cmd_hs   = w_in_cmd & s_cready;
    assign w_beat     = w_in_resp & s_rvalid & w_sel_rready;
    assign w_end_read = w_beat & s_rlast;
    assign w_end_err  = w_in_resp & s_error & w_sel_eack;

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            c_ST_IDLE: begin
                if (m0_cvalid | m1_cvalid) begin
                    w_state_nxt = c_ST_CMD;
                    // On a tie the master that was not served last time wins.
                    if (m0_cvalid & m1_cvalid) begin
                        w_grant_nxt = ~r_last_grant;
                    end else begin
                        w_grant_nxt = m1_cvalid;
                    end
                end
            end
            c_ST_CMD: begin
                if (s_cready) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (w_end_read | w_end_err) begin
                    w_state_nxt      = c_ST_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Command channel: only the granted master is connected while in CMD.
    assign arb_cvalid    = w_in_cmd;
    assign arb_cmd       = w_in_cmd & (r_grant ? m1_cmd : m0_cmd);
    assign arb_addr      = w_in_cmd ? (r_grant ? m1_addr : m0_addr) : '0;
    assign arb_cready_m0 = w_cmd_hs & ~r_grant;
    assign arb_cready_m1 = w_cmd_hs &  r_grant;

    // Response channels: only meaningful while a burst is outstanding.
    assign arb_rready    = w_in_resp & w_sel_rready;
    assign arb_rvalid_m0 = w_in_resp & ~r_grant & s_rvalid;
    assign arb_rvalid_m1 = w_in_resp &  r_grant & s_rvalid;
    assign arb_rlast     = w_in_resp & s_rlast;
    assign arb_rdata     = w_in_resp ? s_rdata : '0;

    assign arb_eack      = w_in_resp & w_sel_eack;
    assign arb_error_m0  = w_in_resp & ~r_grant & s_error;
    assign arb_error_m1  = w_in_resp &  r_grant & s_error;

    bmain_beat_check #(
        .BEATS (BEATS)
    ) u_beat_check (
        .clk_core    (clk_core),
        .reset_n     (reset_n),
        .i_clear     (w_cmd_hs),
        .i_beat      (w_beat),
        .i_last      (s_rlast),
        .o_proto_err (arb_proto_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_bmain_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmain_arb
// Brief    : Self-checking bench for bmain_arb against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bmain_arb;
    import bmain_pkg::*;

    localparam int BEATS = 4;

    logic        clk_core  = 1'b0;
    logic        reset_n   = 1'b0;
    logic        m0_cvalid = 1'b0, m1_cvalid = 1'b0;
    logic        m0_cmd    = 1'b0, m1_cmd    = 1'b0;
    logic [25:0] m0_addr   = '0,   m1_addr   = '0;
    logic        m0_rready = 1'b1, m1_rready = 1'b1;
    logic        m0_eack   = 1'b0, m1_eack   = 1'b0;
    logic        s_cready  = 1'b0;
    logic        s_rvalid  = 1'b0, s_rlast   = 1'b0;
    logic [31:0] s_rdata   = '0;
    logic        s_error   = 1'b0;

    logic        arb_cready_m0, arb_cready_m1, arb_rvalid_m0, arb_rvalid_m1;
    logic        arb_error_m0, arb_error_m1, arb_rlast, arb_cvalid, arb_cmd;
    logic        arb_rready, arb_eack, arb_proto_err;
    logic [31:0] arb_rdata;
    logic [25:0] arb_addr;

    always #5 clk_core = ~clk_core;

    bmain_arb #(.BEATS(BEATS)) dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .m0_cvalid(m0_cvalid), .arb_cready_m0(arb_cready_m0), .m0_cmd(m0_cmd), .m0_addr(m0_addr),
        .arb_rvalid_m0(arb_rvalid_m0), .m0_rready(m0_rready), .arb_error_m0(arb_error_m0), .m0_eack(m0_eack),
        .m1_cvalid(m1_cvalid), .arb_cready_m1(arb_cready_m1), .m1_cmd(m1_cmd), .m1_addr(m1_addr),
        .arb_rvalid_m1(arb_rvalid_m1), .m1_rready(m1_rready), .arb_error_m1(arb_error_m1), .m1_eack(m1_eack),
        .arb_rlast(arb_rlast), .arb_rdata(arb_rdata),
        .arb_cvalid(arb_cvalid), .s_cready(s_cready), .arb_cmd(arb_cmd), .arb_addr(arb_addr),
        .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rdata(s_rdata), .arb_rready(arb_rready),
        .s_error(s_error), .arb_eack(arb_eack), .arb_proto_err(arb_proto_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [69:0] dut_vec();
        return {arb_cready_m0, arb_cready_m1, arb_rvalid_m0, arb_rvalid_m1, arb_rlast, arb_rdata,
                arb_error_m0, arb_error_m1, arb_cvalid, arb_cmd, arb_addr, arb_rready, arb_eack,
                arb_proto_err};
    endfunction

    // Transaction model: phase 0 = idle, 1 = command offered, 2 = burst outstanding.
    int md_phase = 0, md_owner = 0, md_prev = 1, md_pos = 0;
    bit md_perr = 1'b0, md_perr_now = 1'b0, md_rdy = 1'b0, md_ack = 1'b0;
    int md_grants[$];

    always @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            md_phase = 0; md_owner = 0; md_prev = 1; md_pos = 0; md_perr = 1'b0;
        end else begin
            md_perr_now = 1'b0;
            md_rdy = (md_owner == 1) ? m1_rready : m0_rready;
            md_ack = (md_owner == 1) ? m1_eack   : m0_eack;
            if (md_phase == 0) begin
                if (m0_cvalid || m1_cvalid) begin
                    if (m0_cvalid && m1_cvalid) md_owner = 1 - md_prev;
                    else                        md_owner = m1_cvalid ? 1 : 0;
                    md_grants.push_back(md_owner);
                    md_phase = 1;
                end
            end else if (md_phase == 1) begin
                if (s_cready) begin
                    md_phase = 2;
                    md_pos   = 0;
                end
            end else begin
                if (s_rvalid && md_rdy) begin
                    md_pos++;
                    // Beat positions are 1-based; a whole burst ends on a multiple of BEATS.
                    md_perr_now = s_rlast ? (md_pos % BEATS != 0) : (md_pos % BEATS == 0);
                    if (s_rlast) begin
                        md_prev  = md_owner;
                        md_phase = 0;
                    end
                end
                if (s_error && md_ack) begin
                    md_prev  = md_owner;
                    md_phase = 0;
                end
            end
            md_perr = md_perr_now;
        end
    end

    // Per-cycle comparison plus observation queues for the directed checks.
    bit          e_cmd, e_rsp, e_g1;
    logic [69:0] exp_v;
    int          cyc = 0, perr_cnt = 0, perr_cyc = -1, last_cyc = -1;
    int          stall_cnt = 0, err1_cnt = 0, eack_cnt = 0;
    logic [31:0] got0[$], got1[$];
    int          dgr[$];

    always @(negedge clk_core) begin
        cyc++;
        e_cmd = (md_phase == 1);
        e_rsp = (md_phase == 2);
        e_g1  = (md_owner == 1);
        exp_v = {e_cmd && !e_g1 && s_cready, e_cmd && e_g1 && s_cready,
                 e_rsp && !e_g1 && s_rvalid, e_rsp && e_g1 && s_rvalid,
                 e_rsp && s_rlast, (e_rsp ? s_rdata : 32'h0),
                 e_rsp && !e_g1 && s_error, e_rsp && e_g1 && s_error,
                 e_cmd, (e_cmd ? (e_g1 ? m1_cmd : m0_cmd) : 1'b0),
                 (e_cmd ? (e_g1 ? m1_addr : m0_addr) : 26'h0),
                 e_rsp && (e_g1 ? m1_rready : m0_rready),
                 e_rsp && (e_g1 ? m1_eack : m0_eack), md_perr};
        check("cycle_outputs", dut_vec(), exp_v);
        if (reset_n) begin
            if (arb_cready_m0) dgr.push_back(0);
            if (arb_cready_m1) dgr.push_back(1);
            if (arb_rvalid_m0 && arb_rready) got0.push_back(arb_rdata);
            if (arb_rvalid_m1 && arb_rready) got1.push_back(arb_rdata);
            if ((arb_rvalid_m0 || arb_rvalid_m1) && arb_rready && arb_rlast) last_cyc = cyc;
            if (s_rvalid && !arb_rready) stall_cnt++;
            if (arb_proto_err) begin perr_cnt++; perr_cyc = cyc; end
            if (arb_error_m1) err1_cnt++;
            if (arb_eack) eack_cnt++;
        end
    end

    logic [31:0] exp0[$], exp1[$];

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic issue(input logic r0, input logic r1);
        m0_cvalid = r0; m1_cvalid = r1;
        tick();
        s_cready = 1'b1;
        tick();
        s_cready = 1'b0; m0_cvalid = 1'b0; m1_cvalid = 1'b0;
    endtask

    // Slave returns nb beats; master m withholds rready for stall_len cycles at beat stall_at.
    task automatic run_burst(input int m, input int nb, input logic [31:0] base,
                             input int stall_at, input int stall_len);
        int i;
        int st;
        logic rdy;
        i = 0; st = 0;
        while (i < nb) begin
            s_rvalid = 1'b1;
            s_rdata  = base + 32'(i);
            s_rlast  = (i == nb - 1);
            rdy = !((i == stall_at) && (st < stall_len));
            if (m == 0) m0_rready = rdy; else m1_rready = rdy;
            tick();
            if (rdy) begin
                if (m == 0) exp0.push_back(base + 32'(i)); else exp1.push_back(base + 32'(i));
                i++;
            end else begin
                st++;
            end
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
        m0_rready = 1'b1; m1_rready = 1'b1;
    endtask

    int exp_grants[10] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m1_addr = 26'h2AA_5555;
        m1_cmd  = BMAIN_CMD_READ;
        repeat (3) @(posedge clk_core);
        #1;
        check("reset_outputs_zero", dut_vec(), 70'h0);
        reset_n = 1'b1;
        tick();

        // m0 alone, fetch from the boot ROM.
        m0_cmd = BMAIN_CMD_FETCH; m0_addr = 26'h000100; m0_cvalid = 1'b1;
        #1 check("t1_cvalid_same_cycle", arb_cvalid, 0);
        tick();
        check("t1_cvalid_next_cycle", arb_cvalid, 1);
        check("t1_addr", arb_addr, 26'h000100);
        check("t1_cmd", arb_cmd, 1);
        s_cready = 1'b1;
        #1 check("t1_cready_m0", arb_cready_m0, 1);
        check("t1_cready_m1", arb_cready_m1, 0);
        tick();
        s_cready = 1'b0; m0_cvalid = 1'b0;
        run_burst(0, 4, 32'hA000_0000, -1, 0);
        tick();
        check("t1_beats_m0", got0.size(), 4);
        check("t1_beats_m1", got1.size(), 0);

        // m1 stalls for three cycles mid-burst.
        issue(1'b0, 1'b1);
        run_burst(1, 4, 32'hC000_0000, 1, 3);
        tick();
        check("t3_stall_cycles", stall_cnt, 3);
        check("t3_beats_m1", got1.size(), 4);

        // Three same-cycle ties, expected winners m0, m1, m0.
        issue(1'b1, 1'b1); run_burst(0, 4, 32'hB000_0000, -1, 0); tick();
        issue(1'b1, 1'b1); run_burst(1, 4, 32'hB100_0000, -1, 0); tick();
        issue(1'b1, 1'b1); run_burst(0, 4, 32'hB200_0000, -1, 0); tick();

        // m1 error, with s_error already high in CMD (must be ignored there).
        m1_cvalid = 1'b1;
        tick();
        s_error = 1'b1; s_cready = 1'b1;
        #1 check("t4_err_ignored_in_cmd", arb_error_m1, 0);
        tick();
        m1_cvalid = 1'b0; s_cready = 1'b0;
        tick();
        m1_eack = 1'b1;
        tick();
        s_error = 1'b0; m1_eack = 1'b0;
        m0_cvalid = 1'b1;
        tick();
        check("t4_cmd_after_err_bubble", arb_cvalid, 1);
        check("t4_err1_cycles", err1_cnt, 2);
        check("t4_eack_pulses", eack_cnt, 1);

        // Short burst: rlast on the third beat.
        s_cready = 1'b1;
        tick();
        s_cready = 1'b0; m0_cvalid = 1'b0;
        run_burst(0, 3, 32'hD000_0000, -1, 0);
        tick(); tick();
        check("t5_perr_count", perr_cnt, 1);
        check("t5_perr_timing", perr_cyc, last_cyc + 1);

        // Long burst: non-last beat in the final slot, then a misplaced last.
        issue(1'b1, 1'b0);
        run_burst(0, 5, 32'hE000_0000, -1, 0);
        tick(); tick();
        check("t6_perr_count", perr_cnt, 3);

        // Asynchronous reset in the middle of beat 2.
        issue(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'h7700_0000 + 32'(i);
            exp0.push_back(s_rdata);
            tick();
        end
        s_rdata = 32'h7700_0002;
        #1 reset_n = 1'b0;
        #1 check("t7_async_reset_zero", dut_vec(), 70'h0);
        #5 reset_n = 1'b1;
        s_rvalid = 1'b0; s_rdata = '0;
        tick();
        issue(1'b1, 1'b1);
        check("t7_tie_after_reset", dgr.size() > 0 ? dgr[dgr.size()-1] : -1, 0);
        run_burst(0, 4, 32'hF000_0000, -1, 0);
        tick(); tick();

        check("grant_count_dut", dgr.size(), 10);
        check("grant_count_model", md_grants.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < dgr.size())       check($sformatf("grant_dut_%0d", i), dgr[i], exp_grants[i]);
            if (i < md_grants.size()) check($sformatf("grant_model_%0d", i), md_grants[i], exp_grants[i]);
        end
        check("beats_m0_total", got0.size(), exp0.size());
        check("beats_m1_total", got1.size(), exp1.size());
        for (int i = 0; i < got0.size() && i < exp0.size(); i++)
            check($sformatf("data_m0_%0d", i), got0[i], exp0[i]);
        for (int i = 0; i < got1.size() && i < exp1.size(); i++)
            check($sformatf("data_m1_%0d", i), got1[i], exp1[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
